// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register word offsets (addr[3:2])
//   - STATUS register bit positions
//   - bit-timing FSM state encoding
package uart_pkg;

    // Word index within the peripheral window (addr[3:2]).
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS register layout.
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVR   = 3;
    localparam int ST_CNT   = 8;   // count field occupies [ST_CNT +: CNT_W]

    // Bit-timing FSM states. S_PARITY is only reachable with UART_PARITY_EN.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART shifter.
//   clk, reset   core clock, asynchronous active-low reset (flushes the FIFO)
//   push, din    enqueue din; ignored when full (full is the pre-edge value)
//   pop          dequeue head; ignored when empty
//   dout         current head entry
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
// Pointers are log2(DEPTH) wide so they wrap modulo DEPTH for free.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: a flushed FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: memory-mapped UART transmitter (bus responder + 8N1 serialiser).
//   clk     core clock, rising edge
//   reset   asynchronous active-low reset
//   sel     address decode hit for this peripheral
//   we      store size (00 none, else store; only wdata[7:0] matters)
//   addr    byte offset in window; addr[3:2] selects the register
//   wdata   store data
//   rdata   load data, combinational (0 when sel=0)
//   tx      serial line, idle high, LSB first
//   tx_irq  level: FIFO empty and shifter idle
// Registers: 0x0 TXDATA (W push byte, R 0), 0x4 STATUS (R flags/count,
// W bit3=1 clears sticky overrun), 0x8/0xC reserved.
// Optional feature macro: UART_PARITY_EN inserts an even-parity bit after DATA.
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_irq
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Bus decode
    logic wr_en, wr_txdata, wr_status;
    assign wr_en     = sel && (we != 2'b00);
    assign wr_txdata = wr_en && (addr[3:2] == REG_TXDATA);
    assign wr_status = wr_en && (addr[3:2] == REG_STATUS);

    // FIFO
    logic             pop;
    logic [7:0]       fifo_dout;
    logic             full, empty;
    logic [CNT_W-1:0] count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .din   (wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Sticky overrun: a push seen while full (pre-edge) sets it, even if the
    // shifter pops on the same edge. Set beats a simultaneous clear.
    logic ovr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      ovr <= 1'b0;
        else if (wr_txdata && full)      ovr <= 1'b1;
        else if (wr_status && wdata[3])  ovr <= 1'b0;
    end

    // Bit-timing FSM
    tx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              baud_end;

    assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_dout;
                    baud_n  = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n  = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end else begin
                    baud_n  = baud + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    // Chain straight into the next frame: no idle bit time.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_dout;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line driven straight from state so an async reset forces it high at once.
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shreg[bit_cnt];
`ifdef UART_PARITY_EN
            S_PARITY: tx = ^shreg;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign tx_irq = empty && (state == S_IDLE);

    // Load path
    always_comb begin
        rdata = '0;
        if (sel && (addr[3:2] == REG_STATUS)) begin
            rdata[ST_FULL]          = full;
            rdata[ST_EMPTY]         = empty;
            rdata[ST_BUSY]          = (state != S_IDLE);
            rdata[ST_OVR]           = ovr;
            rdata[ST_CNT +: CNT_W]  = count;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: directed + randomized bench for uart_mmio_tx (CLKS_PER_BIT=4).
// The reference model tracks the FIFO as a queue and each frame as a start
// cycle plus a byte; the expected line level is derived arithmetically from
// the cycle offset into the frame.
module tb_uart_mmio_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  we = 2'b00;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_irq;

    always #5 clk = ~clk;

    uart_mmio_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .tx     (tx),
        .tx_irq (tx_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_idle = 1'b1;
    bit         m_ovr  = 1'b0;
    logic [7:0] m_byte = 8'h0;
    int         cyc = 0;
    int         m_start = 0;
    int         m_end = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_idle = 1'b1;
            m_ovr  = 1'b0;
        end else begin
            bit full_pre, wr, wr_tx, wr_st, set_ovr;
            cyc++;
            full_pre = (mq.size() == DEPTH);
            wr       = sel && (we != 2'b00);
            wr_tx    = wr && (addr[3:2] == 2'd0);
            wr_st    = wr && (addr[3:2] == 2'd1);
            set_ovr  = 1'b0;
            // A frame starts when the line is free and a byte is waiting
            // (byte written this edge is not yet visible).
            if ((m_idle || cyc == m_end) && mq.size() != 0) begin
                m_byte  = mq.pop_front();
                m_start = cyc;
                m_end   = cyc + FRAME * CPB;
                m_idle  = 1'b0;
            end else if (!m_idle && cyc == m_end) begin
                m_idle = 1'b1;
            end
            if (wr_tx) begin
                if (full_pre) set_ovr = 1'b1;
                else          mq.push_back(wdata[7:0]);
            end
            if (set_ovr)                 m_ovr = 1'b1;
            else if (wr_st && wdata[3])  m_ovr = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int off, b;
        if (m_idle) return 1'b1;
        off = cyc - m_start;
        b   = off / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0]      = (mq.size() == DEPTH);
        s[1]      = (mq.size() == 0);
        s[2]      = !m_idle;
        s[3]      = m_ovr;
        s[8 +: CW] = CW'(mq.size());
        return s;
    endfunction

    // Continuous line / irq monitor against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_line", {31'b0, tx}, {31'b0, exp_tx()});
            chk("tx_irq", {31'b0, tx_irq}, {31'b0, (m_idle && mq.size() == 0)});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wrw(input logic [3:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        #1;
        sel = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 2'b00;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wrw(a, d, 2'b01);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        #1;
        sel = 1'b1; we = 2'b00; addr = a;
        #1;
        v = rdata;
        sel = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_idle && mq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, done}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] v;
        bit          found;
        int          lows;

        // Reset state
        repeat (3) @(negedge clk);
        rd(4'h4, v);
        chk("status_in_reset", v, 32'h2);
        chk("tx_in_reset", {31'b0, tx}, 32'h1);
        @(negedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;
        rd(4'h4, v);
        chk("status_after_reset", v, 32'h2);
        chk("irq_after_reset", {31'b0, tx_irq}, 32'h1);
        rd(4'h0, v);
        chk("txdata_reads_zero", v, 32'h0);
        rd(4'h8, v);
        chk("reserved_reads_zero", v, 32'h0);
        @(negedge clk);
        #1 sel = 1'b0; addr = 4'h4;
        #1 chk("nosel_reads_zero", rdata, 32'h0);

        // Single frame 0x55: idle one more cycle, then start bit
        wr(4'h0, 32'h55);
        @(negedge clk);
        chk("idle_after_write_edge", {31'b0, tx}, 32'h1);
        @(negedge clk);
        chk("start_bit", {31'b0, tx}, 32'h0);
        rd(4'h4, v);
        chk("status_busy", v, 32'h6);
        wait_idle(200, "drain_55");
        rd(4'h4, v);
        chk("status_after_55", v, 32'h2);

        // Back-to-back frames
        wr(4'h0, 32'hA3);
        wr(4'h0, 32'h0F);
        rd(4'h4, v);
        chk("b2b_count1", v, 32'h0104);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_idle && m_byte == 8'h0F) begin found = 1'b1; break; end
        end
        chk("b2b_second_frame", {31'b0, found}, 32'h1);
        rd(4'h4, v);
        chk("b2b_count0", v, 32'h0006);
        wait_idle(200, "drain_b2b");

        // Overflow: 17 writes while the shifter is busy
        wr(4'h0, $urandom);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) wr(4'h0, $urandom);
        rd(4'h4, v);
        chk("full_ovr", v, 32'h100D);
        wr(4'h4, 32'h8);
        rd(4'h4, v);
        chk("ovr_cleared", v, 32'h1005);

        // Write landing exactly on the pop edge while full
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cyc == m_end - 1) begin found = 1'b1; break; end
        end
        chk("pop_edge_found", {31'b0, found}, 32'h1);
        #1;
        sel = 1'b1; we = 2'b11; addr = 4'h0; wdata = $urandom;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 2'b00;
        rd(4'h4, v);
        chk("pop_edge_drop", v, 32'h0F0C);
        chk("pop_edge_model", v, m_status());
        wr(4'h4, 32'h8);
        wait_idle(17 * FRAME * CPB + 100, "drain_full");

        // Randomized bus traffic
        for (int i = 0; i < 40; i++) begin
            int op;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            op = $urandom_range(0, 9);
            if (op <= 5)
                wrw({2'b00, 2'($urandom)}, $urandom, 2'($urandom_range(1, 3)));
            else if (op == 6)
                wrw({2'b01, 2'($urandom)}, $urandom, 2'($urandom_range(1, 3)));
            else if (op == 7)
                wrw({1'b1, 3'($urandom)}, $urandom, 2'($urandom_range(1, 3)));
            else if (op == 8)
                wrw(4'h0, $urandom, 2'b00);
            else begin
                rd(4'h4, v);
                chk("rand_status", v, m_status());
            end
        end
        wait_idle(17 * FRAME * CPB + 100, "drain_rand");
        rd(4'h4, v);
        chk("rand_final_status", v, m_status());

        // Reset in the middle of a 0xFF frame
        wr(4'h0, 32'hFF);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!m_idle && (cyc - m_start) >= 10) begin found = 1'b1; break; end
        end
        chk("mid_data_reached", {31'b0, found}, 32'h1);
        #2 reset = 1'b0;
        #1 chk("reset_tx_immediate", {31'b0, tx}, 32'h1);
        rd(4'h4, v);
        chk("status_mid_reset", v, 32'h2);
        @(negedge clk);
        #1 reset = 1'b1;
        rd(4'h4, v);
        chk("status_post_reset", v, 32'h2);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("no_frames_after_reset", lows, 32'h0);
        chk("irq_post_reset", {31'b0, tx_irq}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
